// File: rtl/control_muestreo_adc.sv
// -----------------------------------------------------------------------------
// control_muestreo_adc
//
// Periodic sample controller for an ADC protocol block that runs on a divided
// clock. Every PERIODO cycles it raises a conversion request (start), waits for
// the synchronised done level to rise, and accumulates the returned sample.
// After 2^LOG2_PROM samples it publishes their truncated average on
// Dato_Promedio together with a one-cycle valid pulse.
//
// Parameters
//   PERIODO    cycles between sample requests
//   LOG2_PROM  log2 of the number of samples averaged (0..4)
//   TIMEOUT    maximum cycles start may stay high without a done rise
//
// Ports
//   Clock_Nexys    in   system clock, all logic on its rising edge
//   Reset          in   synchronous, active-low reset
//   enable         in   1 = periodic sampling, 0 = stop and discard partial work
//   done           in   conversion-finished level (divided-clock domain)
//   Dato[11:0]     in   converted sample, stable while done is high
//   start          out  conversion request level, held until done is seen
//   Dato_Promedio  out  averaged result
//   valid          out  one-cycle pulse, Dato_Promedio just updated
//   busy           out  controller is not idle
//   error_timeout  out  sticky, a conversion never answered within TIMEOUT
//   overrun        out  sticky, a period tick arrived while still converting
// -----------------------------------------------------------------------------
module control_muestreo_adc #(
    parameter int PERIODO   = 100000,
    parameter int LOG2_PROM = 2,
    parameter int TIMEOUT   = 4096
) (
    input  logic        Clock_Nexys,
    input  logic        Reset,
    input  logic        enable,
    input  logic        done,
    input  logic [11:0] Dato,
    output logic        start,
    output logic [11:0] Dato_Promedio,
    output logic        valid,
    output logic        busy,
    output logic        error_timeout,
    output logic        overrun
);

    localparam int ACC_W = 12 + LOG2_PROM;
    localparam int CNT_W = LOG2_PROM + 1;
    localparam int PER_W = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [PER_W-1:0] PER_MAX    = PER_W'(PERIODO - 1);
    localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] N_MUESTRAS = CNT_W'(1 << LOG2_PROM);

    typedef enum logic [2:0] {
        IDLE,
        ESPERA_BAJO,
        ARRANQUE,
        CAPTURA,
        SALIDA
    } estado_t;

    estado_t state;
    estado_t state_next;

    logic             done_m;
    logic             done_s;
    logic             done_s_prev;
    logic             done_rise;

    logic [PER_W-1:0] periodo_cnt;
    logic             tick;

    logic [TO_W-1:0]  timeout_cnt;
    logic             timeout_exp;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] muestra_cnt;
    logic [CNT_W-1:0] muestra_cnt_inc;
    logic             ultima_muestra;

    logic [11:0]      promedio_r;
    logic             error_r;
    logic             overrun_r;

    // done comes from the divided-clock domain: two flops bring it in, and a
    // third copy of the synchronised level gives the rising-edge detector.
    always_ff @(posedge Clock_Nexys) begin
        if (!Reset) begin
            done_m      <= 1'b0;
            done_s      <= 1'b0;
            done_s_prev <= 1'b0;
        end else begin
            done_m      <= done;
            done_s      <= done_m;
            done_s_prev <= done_s;
        end
    end

    assign done_rise = done_s & ~done_s_prev;

    // Free-running period counter; it is parked at zero while sampling is
    // disabled so the first request after enabling comes a full period later.
    always_ff @(posedge Clock_Nexys) begin
        if (!Reset || !enable) begin
            periodo_cnt <= '0;
        end else if (periodo_cnt == PER_MAX) begin
            periodo_cnt <= '0;
        end else begin
            periodo_cnt <= periodo_cnt + PER_W'(1);
        end
    end

    assign tick = enable && (periodo_cnt == PER_MAX);

    assign acc_sum         = acc + ACC_W'(Dato);
    assign muestra_cnt_inc = muestra_cnt + CNT_W'(1);
    assign ultima_muestra  = (muestra_cnt_inc == N_MUESTRAS);

    // State register.
    always_ff @(posedge Clock_Nexys) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs. A done rise wins over a timeout that
    // expires in the same cycle, since the sample is genuinely there.
    always_comb begin
        state_next  = state;
        timeout_exp = 1'b0;
        start       = 1'b0;
        valid       = 1'b0;
        busy        = (state != IDLE);

        case (state)
            IDLE: begin
                if (tick) begin
                    state_next = ESPERA_BAJO;
                end
            end
            ESPERA_BAJO: begin
                if (!done_s) begin
                    state_next = ARRANQUE;
                end
            end
            ARRANQUE: begin
                start = 1'b1;
                if (done_rise) begin
                    state_next = CAPTURA;
                end else if (timeout_cnt == TO_MAX) begin
                    timeout_exp = 1'b1;
                    state_next  = IDLE;
                end
            end
            CAPTURA: begin
                if (ultima_muestra) begin
                    state_next = SALIDA;
                end else begin
                    state_next = IDLE;
                end
            end
            SALIDA: begin
                valid      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (!enable) begin
            state_next = IDLE;
        end
    end

    // Datapath. The average is loaded on the edge that enters SALIDA so that
    // Dato_Promedio already shows the new value during the valid cycle; the
    // accumulator is emptied on that same edge. Ticks that find the FSM busy
    // are simply dropped and only leave a trace in the sticky overrun flag.
    always_ff @(posedge Clock_Nexys) begin
        if (!Reset) begin
            acc         <= '0;
            muestra_cnt <= '0;
            timeout_cnt <= '0;
            promedio_r  <= '0;
            error_r     <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (tick && (state != IDLE)) begin
                overrun_r <= 1'b1;
            end

            if (!enable) begin
                acc         <= '0;
                muestra_cnt <= '0;
                timeout_cnt <= '0;
            end else begin
                case (state)
                    ARRANQUE: begin
                        if (done_rise || timeout_exp) begin
                            timeout_cnt <= '0;
                        end else begin
                            timeout_cnt <= timeout_cnt + TO_W'(1);
                        end
                        if (timeout_exp) begin
                            error_r     <= 1'b1;
                            acc         <= '0;
                            muestra_cnt <= '0;
                        end
                    end
                    CAPTURA: begin
                        if (ultima_muestra) begin
                            promedio_r  <= 12'(acc_sum >> LOG2_PROM);
                            acc         <= '0;
                            muestra_cnt <= '0;
                        end else begin
                            acc         <= acc_sum;
                            muestra_cnt <= muestra_cnt_inc;
                        end
                    end
                    default: begin
                        timeout_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign Dato_Promedio = promedio_r;
    assign error_timeout = error_r;
    assign overrun       = overrun_r;

endmodule

// File: tb/tb_control_muestreo_adc.sv
// -----------------------------------------------------------------------------
// tb_control_muestreo_adc
//
// Bench for control_muestreo_adc with PERIODO=20, LOG2_PROM=2, TIMEOUT=50.
// An ADC responder answers start after a programmable delay, handing out
// samples from a queue. Each delivered sample feeds a group model: every four
// samples give a plain integer average which must appear on Dato_Promedio with
// a valid pulse four clocks after done was raised (two synchroniser flops, one
// capture cycle, one output cycle). A negedge process compares valid and
// Dato_Promedio against that model on every cycle out of reset.
// -----------------------------------------------------------------------------
module tb_control_muestreo_adc;

    localparam int PERIODO   = 20;
    localparam int LOG2_PROM = 2;
    localparam int TIMEOUT   = 50;
    localparam int N_AVG     = 4;

    logic        clk = 1'b0;
    logic        Reset;
    logic        enable;
    logic        done;
    logic [11:0] Dato;
    logic        start;
    logic [11:0] Dato_Promedio;
    logic        valid;
    logic        busy;
    logic        error_timeout;
    logic        overrun;

    control_muestreo_adc #(
        .PERIODO   (PERIODO),
        .LOG2_PROM (LOG2_PROM),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .Clock_Nexys   (clk),
        .Reset         (Reset),
        .enable        (enable),
        .done          (done),
        .Dato          (Dato),
        .start         (start),
        .Dato_Promedio (Dato_Promedio),
        .valid         (valid),
        .busy          (busy),
        .error_timeout (error_timeout),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [11:0] avg;
    } exp_t;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          adc_delay = 3;
    bit          adc_mute = 1'b0;
    int          n_delivered = 0;
    int          wait_cnt = 0;
    exp_t        exp_q[$];
    logic [11:0] model_samples[$];
    logic [11:0] samp_q[$];
    logic [11:0] last_avg = '0;
    logic        exp_valid;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic applyStimulus(input int n, input logic [11:0] v0, input logic [11:0] v1,
                                 input logic [11:0] v2, input logic [11:0] v3, input int delay);
        logic [11:0] v[4];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        for (int i = 0; i < n; i++) samp_q.push_back(v[i]);
        adc_delay = delay;
    endtask

    // Group model: four delivered samples make one expected average.
    task automatic model_sample(input logic [11:0] s);
        int   sum;
        exp_t e;
        model_samples.push_back(s);
        if (model_samples.size() == N_AVG) begin
            sum = 0;
            foreach (model_samples[k]) sum += int'(model_samples[k]);
            e.due = cyc + 4;
            e.avg = 12'(sum / N_AVG);
            exp_q.push_back(e);
            model_samples.delete();
        end
    endtask

    // ADC responder: raises done after adc_delay cycles of start, holds Dato
    // and done until start falls.
    initial begin
        done = 1'b0;
        Dato = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!Reset) begin
                done     = 1'b0;
                wait_cnt = 0;
            end else if (start && !done && !adc_mute) begin
                if (wait_cnt >= adc_delay) begin
                    if (samp_q.size() > 0) Dato = samp_q.pop_front();
                    else Dato = 12'h000;
                    done     = 1'b1;
                    wait_cnt = 0;
                    n_delivered++;
                    model_sample(Dato);
                end else begin
                    wait_cnt++;
                end
            end else if (!start) begin
                done     = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!Reset) begin
            exp_q.delete();
            model_samples.delete();
            last_avg = '0;
        end else begin
            exp_valid = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            checkOutput("valid", {31'd0, valid}, {31'd0, exp_valid});
            if (exp_valid) begin
                last_avg = exp_q[0].avg;
                void'(exp_q.pop_front());
            end
            checkOutput("Dato_Promedio", {20'd0, Dato_Promedio}, {20'd0, last_avg});
        end
    end

    task automatic waitValid(input string name, input logic [11:0] expected);
        int i;
        i = 0;
        @(negedge clk);
        while (!valid && i < 600) begin
            @(negedge clk);
            i++;
        end
        checkOutput({name, "_valid_seen"}, {31'd0, valid}, 32'd1);
        checkOutput(name, {20'd0, Dato_Promedio}, {20'd0, expected});
    endtask

    task automatic stopSampling();
        @(posedge clk);
        #1;
        enable = 1'b0;
        model_samples.delete();
        samp_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int hi;
        int i;
        int target;

        Reset  = 1'b0;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_start", {31'd0, start}, 32'd0);
        checkOutput("reset_valid", {31'd0, valid}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_promedio", {20'd0, Dato_Promedio}, 32'd0);
        checkOutput("reset_error_timeout", {31'd0, error_timeout}, 32'd0);
        checkOutput("reset_overrun", {31'd0, overrun}, 32'd0);
        @(posedge clk);
        #1 Reset = 1'b1;

        // Ramp of four samples; also pins enable-to-start latency.
        $display("[TB] ramp 0x100..0x400");
        applyStimulus(4, 12'h100, 12'h200, 12'h300, 12'h400, 3);
        @(posedge clk);
        #1 enable = 1'b1;
        lat = 0;
        while (!start && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("enable_to_start_latency", lat, 32'd21);
        waitValid("avg_ramp", 12'h280);
        checkOutput("overrun_clear_fast", {31'd0, overrun}, 32'd0);
        stopSampling();

        // Full-scale samples.
        $display("[TB] full scale 0xFFF");
        applyStimulus(4, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 3);
        @(posedge clk);
        #1 enable = 1'b1;
        waitValid("avg_full_scale", 12'hFFF);
        stopSampling();

        // Slow ADC: ticks land in ARRANQUE, average must still be right.
        $display("[TB] slow ADC, overrun");
        checkOutput("overrun_before_slow", {31'd0, overrun}, 32'd0);
        applyStimulus(4, 12'h123, 12'h456, 12'h789, 12'hABC, 30);
        @(posedge clk);
        #1 enable = 1'b1;
        waitValid("avg_slow_truncated", 12'h5EF);
        checkOutput("overrun_after_slow", {31'd0, overrun}, 32'd1);
        checkOutput("no_timeout_slow", {31'd0, error_timeout}, 32'd0);
        stopSampling();

        // Two samples, disable, re-enable: only fresh samples count.
        $display("[TB] enable toggle mid-group");
        target = n_delivered + 2;
        applyStimulus(2, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 3);
        @(posedge clk);
        #1 enable = 1'b1;
        i = 0;
        while (n_delivered < target && i < 200) begin
            @(negedge clk);
            i++;
        end
        checkOutput("two_samples_delivered", n_delivered, target);
        i = 0;
        @(negedge clk);
        while (busy && i < 20) begin
            @(negedge clk);
            i++;
        end
        checkOutput("idle_before_disable", {31'd0, busy}, 32'd0);
        stopSampling();
        checkOutput("promedio_retained", {20'd0, Dato_Promedio}, 32'h5EF);
        checkOutput("overrun_retained", {31'd0, overrun}, 32'd1);
        applyStimulus(4, 12'h004, 12'h008, 12'h00C, 12'h010, 3);
        @(posedge clk);
        #1 enable = 1'b1;
        waitValid("avg_fresh_after_toggle", 12'h00A);
        stopSampling();

        // ADC never answers: start high exactly TIMEOUT cycles.
        $display("[TB] timeout");
        adc_mute = 1'b1;
        @(posedge clk);
        #1 enable = 1'b1;
        i = 0;
        @(negedge clk);
        while (!start && i < 100) begin
            @(negedge clk);
            i++;
        end
        checkOutput("timeout_start_seen", {31'd0, start}, 32'd1);
        hi = 0;
        while (start && hi < 200) begin
            hi++;
            @(negedge clk);
        end
        checkOutput("timeout_start_width", hi, 32'd50);
        checkOutput("error_timeout_set", {31'd0, error_timeout}, 32'd1);
        checkOutput("idle_after_timeout", {31'd0, busy}, 32'd0);
        adc_mute = 1'b0;
        applyStimulus(4, 12'h010, 12'h020, 12'h030, 12'h041, 3);
        waitValid("avg_after_timeout", 12'h028);
        stopSampling();

        // Reset while start is high.
        $display("[TB] reset mid-conversion");
        applyStimulus(4, 12'h111, 12'h222, 12'h333, 12'h444, 10);
        @(posedge clk);
        #1 enable = 1'b1;
        i = 0;
        @(negedge clk);
        while (!start && i < 100) begin
            @(negedge clk);
            i++;
        end
        checkOutput("reset_mid_start_seen", {31'd0, start}, 32'd1);
        @(posedge clk);
        #1 Reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midreset_start", {31'd0, start}, 32'd0);
        checkOutput("midreset_valid", {31'd0, valid}, 32'd0);
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset_promedio", {20'd0, Dato_Promedio}, 32'd0);
        checkOutput("midreset_error_timeout", {31'd0, error_timeout}, 32'd0);
        checkOutput("midreset_overrun", {31'd0, overrun}, 32'd0);
        enable = 1'b0;
        samp_q.delete();
        @(posedge clk);
        #1 Reset = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("no_pending_valid", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
